// File: rtl/branch_checkpoint_queue_if.sv
`default_nettype none
// ============================================================================
// branch_checkpoint_queue_if : alloc/resolve/update/recover bundle for the queue
// Rev 1.0
// ============================================================================
interface branch_checkpoint_queue_if #(
  parameter int TAG_W  = 3,
  parameter int HIST_W = 11,
  parameter int RAS_W  = 5
);
  logic              alloc_valid_i;
  logic              alloc_ready_o;
  logic [31:0]       alloc_pc_i;
  logic              alloc_pred_taken_i;
  logic [31:0]       alloc_pred_target_i;
  logic              alloc_target_valid_i;
  logic [HIST_W-1:0] alloc_history_i;
  logic [RAS_W-1:0]  alloc_ras_tos_i;
  logic              alloc_is_branch_i;
  logic              alloc_is_call_i;
  logic              alloc_is_return_i;
  logic [TAG_W-1:0]  alloc_tag_o;

  logic              resolve_valid_i;
  logic [TAG_W-1:0]  resolve_tag_i;
  logic              resolve_taken_i;
  logic [31:0]       resolve_target_i;

  logic              update_valid_o;
  logic [31:0]       update_pc_o;
  logic              update_taken_o;
  logic [31:0]       update_target_o;
  logic              update_is_branch_o;
  logic              update_is_call_o;
  logic              update_is_return_o;
  logic [HIST_W-1:0] update_history_o;

  logic              mispredict_o;
  logic [HIST_W-1:0] recover_history_o;
  logic [RAS_W-1:0]  recover_ras_tos_o;
  logic [31:0]       redirect_pc_o;
  logic [TAG_W:0]    count_o;

  modport slave (
    input  alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
           alloc_target_valid_i, alloc_history_i, alloc_ras_tos_i,
           alloc_is_branch_i, alloc_is_call_i, alloc_is_return_i,
           resolve_valid_i, resolve_tag_i, resolve_taken_i, resolve_target_i,
    output alloc_ready_o, alloc_tag_o,
           update_valid_o, update_pc_o, update_taken_o, update_target_o,
           update_is_branch_o, update_is_call_o, update_is_return_o, update_history_o,
           mispredict_o, recover_history_o, recover_ras_tos_o, redirect_pc_o, count_o
  );

  modport master (
    output alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
           alloc_target_valid_i, alloc_history_i, alloc_ras_tos_i,
           alloc_is_branch_i, alloc_is_call_i, alloc_is_return_i,
           resolve_valid_i, resolve_tag_i, resolve_taken_i, resolve_target_i,
    input  alloc_ready_o, alloc_tag_o,
           update_valid_o, update_pc_o, update_taken_o, update_target_o,
           update_is_branch_o, update_is_call_o, update_is_return_o, update_history_o,
           mispredict_o, recover_history_o, recover_ras_tos_o, redirect_pc_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/branch_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// branch_checkpoint_queue : in-order branch checkpoint queue, out-of-order resolve
// Rev 1.0
// ============================================================================
module branch_checkpoint_queue #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int HIST_W = 11,
  parameter int RAS_W  = 5
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                flush_i,
  branch_checkpoint_queue_if.slave bus
);

  typedef logic [TAG_W:0]   ptr_t;
  typedef logic [TAG_W-1:0] idx_t;

  logic [DEPTH-1:0]  valid_q, valid_d, resolved_q, resolved_d;
  ptr_t              head_q, head_d, tail_q, tail_d;

  logic [31:0]       pc_q          [DEPTH];
  logic [31:0]       pred_target_q [DEPTH];
  logic [31:0]       act_target_q  [DEPTH];
  logic [HIST_W-1:0] history_q     [DEPTH];
  logic [RAS_W-1:0]  ras_tos_q     [DEPTH];
  logic [DEPTH-1:0]  pred_taken_q, target_valid_q, act_taken_q;
  logic [DEPTH-1:0]  is_branch_q, is_call_q, is_return_q;

  logic              mispredict_q;
  logic [HIST_W-1:0] recover_history_q;
  logic [RAS_W-1:0]  recover_ras_tos_q;
  logic [31:0]       redirect_pc_q;
  logic              update_valid_q;
  logic [31:0]       update_pc_q, update_target_q;
  logic              update_taken_q, update_is_branch_q, update_is_call_q, update_is_return_q;
  logic [HIST_W-1:0] update_history_q;

  idx_t w_head_idx, w_tail_idx, w_res_tag, w_res_off;
  logic w_full, w_alloc_ready, w_alloc_fire, w_res_hit, w_mp_cond, w_mp_fire, w_retire;
  ptr_t w_mp_tail;

  assign w_head_idx    = head_q[TAG_W-1:0];
  assign w_tail_idx    = tail_q[TAG_W-1:0];
  assign w_res_tag     = bus.resolve_tag_i;
  assign w_full        = (w_head_idx == w_tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign w_alloc_ready = !w_full && !mispredict_q;

  assign w_res_hit = bus.resolve_valid_i && valid_q[w_res_tag] && !resolved_q[w_res_tag] && !flush_i;
  assign w_mp_cond = (bus.resolve_taken_i != pred_taken_q[w_res_tag]) ||
                     (bus.resolve_taken_i && (!target_valid_q[w_res_tag] ||
                      (bus.resolve_target_i != pred_target_q[w_res_tag])));
  assign w_mp_fire = w_res_hit && w_mp_cond;

  // An alloc racing a mispredict belongs to the wrong path and is dropped.
  assign w_alloc_fire = bus.alloc_valid_i && w_alloc_ready && !w_mp_fire && !flush_i;
  // Retire never lands in the same output cycle as a recovery pulse.
  assign w_retire = valid_q[w_head_idx] && resolved_q[w_head_idx] &&
                    !mispredict_q && !w_mp_fire && !flush_i;

  // Age of the resolving entry relative to head; the tail is rebuilt just past it.
  assign w_res_off = w_res_tag - w_head_idx;
  assign w_mp_tail = head_q + {1'b0, w_res_off} + ptr_t'(1);

  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (w_retire) begin
      valid_d[w_head_idx]    = 1'b0;
      resolved_d[w_head_idx] = 1'b0;
      head_d                 = head_q + ptr_t'(1);
    end
    if (w_res_hit) begin
      resolved_d[w_res_tag] = 1'b1;
    end
    if (w_mp_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((idx_t'(i) - w_head_idx) > w_res_off) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d = w_mp_tail;
    end else if (w_alloc_fire) begin
      valid_d[w_tail_idx]    = 1'b1;
      resolved_d[w_tail_idx] = 1'b0;
      tail_d                 = tail_q + ptr_t'(1);
    end
    if (flush_i) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      pc_q[w_tail_idx]           <= bus.alloc_pc_i;
      pred_taken_q[w_tail_idx]   <= bus.alloc_pred_taken_i;
      pred_target_q[w_tail_idx]  <= bus.alloc_pred_target_i;
      target_valid_q[w_tail_idx] <= bus.alloc_target_valid_i;
      history_q[w_tail_idx]      <= bus.alloc_history_i;
      ras_tos_q[w_tail_idx]      <= bus.alloc_ras_tos_i;
      is_branch_q[w_tail_idx]    <= bus.alloc_is_branch_i;
      is_call_q[w_tail_idx]      <= bus.alloc_is_call_i;
      is_return_q[w_tail_idx]    <= bus.alloc_is_return_i;
    end
    if (w_res_hit) begin
      act_taken_q[w_res_tag]  <= bus.resolve_taken_i;
      act_target_q[w_res_tag] <= bus.resolve_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q            <= '0;
      resolved_q         <= '0;
      head_q             <= '0;
      tail_q             <= '0;
      mispredict_q       <= 1'b0;
      recover_history_q  <= '0;
      recover_ras_tos_q  <= '0;
      redirect_pc_q      <= '0;
      update_valid_q     <= 1'b0;
      update_pc_q        <= '0;
      update_taken_q     <= 1'b0;
      update_target_q    <= '0;
      update_is_branch_q <= 1'b0;
      update_is_call_q   <= 1'b0;
      update_is_return_q <= 1'b0;
      update_history_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      resolved_q     <= resolved_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      mispredict_q   <= w_mp_fire;
      update_valid_q <= w_retire;
      if (w_mp_fire) begin
        recover_history_q <= history_q[w_res_tag];
        recover_ras_tos_q <= ras_tos_q[w_res_tag];
        redirect_pc_q     <= bus.resolve_taken_i ? bus.resolve_target_i
                                                 : (pc_q[w_res_tag] + 32'd4);
      end
      if (w_retire) begin
        update_pc_q        <= pc_q[w_head_idx];
        update_taken_q     <= act_taken_q[w_head_idx];
        update_target_q    <= act_target_q[w_head_idx];
        update_is_branch_q <= is_branch_q[w_head_idx];
        update_is_call_q   <= is_call_q[w_head_idx];
        update_is_return_q <= is_return_q[w_head_idx];
        update_history_q   <= history_q[w_head_idx];
      end
    end
  end

  assign bus.alloc_ready_o      = w_alloc_ready;
  assign bus.alloc_tag_o        = w_tail_idx;
  assign bus.count_o            = tail_q - head_q;
  assign bus.mispredict_o       = mispredict_q;
  assign bus.recover_history_o  = recover_history_q;
  assign bus.recover_ras_tos_o  = recover_ras_tos_q;
  assign bus.redirect_pc_o      = redirect_pc_q;
  assign bus.update_valid_o     = update_valid_q;
  assign bus.update_pc_o        = update_pc_q;
  assign bus.update_taken_o     = update_taken_q;
  assign bus.update_target_o    = update_target_q;
  assign bus.update_is_branch_o = update_is_branch_q;
  assign bus.update_is_call_o   = update_is_call_q;
  assign bus.update_is_return_o = update_is_return_q;
  assign bus.update_history_o   = update_history_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_queue.sv
`default_nettype none
// ============================================================================
// tb_branch_checkpoint_queue : directed + random bench with a queue-based model
// Rev 1.0
// ============================================================================
module tb_branch_checkpoint_queue;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int HIST_W = 11;
  localparam int RAS_W  = 5;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [31:0]       pc;
    logic              pt;
    logic [31:0]       ptgt;
    logic              tv;
    logic [HIST_W-1:0] hist;
    logic [RAS_W-1:0]  ras;
    logic              br, ca, re;
    logic              res;
    logic              at;
    logic [31:0]       atgt;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  branch_checkpoint_queue_if #(.TAG_W(TAG_W), .HIST_W(HIST_W), .RAS_W(RAS_W)) bus ();

  branch_checkpoint_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .HIST_W(HIST_W), .RAS_W(RAS_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  // Reference model: ordered list of live checkpoints plus the expected registered outputs.
  ent_t              mq[$];
  int                m_tail;
  logic              e_mp, e_uv;
  logic [31:0]       e_redir;
  logic [HIST_W-1:0] e_rhist;
  logic [RAS_W-1:0]  e_rras;
  ent_t              e_upd;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush                    = 1'b0;
    bus.alloc_valid_i        = 1'b0;
    bus.alloc_pc_i           = '0;
    bus.alloc_pred_taken_i   = 1'b0;
    bus.alloc_pred_target_i  = '0;
    bus.alloc_target_valid_i = 1'b0;
    bus.alloc_history_i      = '0;
    bus.alloc_ras_tos_i      = '0;
    bus.alloc_is_branch_i    = 1'b0;
    bus.alloc_is_call_i      = 1'b0;
    bus.alloc_is_return_i    = 1'b0;
    bus.resolve_valid_i      = 1'b0;
    bus.resolve_tag_i        = '0;
    bus.resolve_taken_i      = 1'b0;
    bus.resolve_target_i     = '0;
  endtask

  task automatic drive_alloc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                             input logic tv, input logic [HIST_W-1:0] h);
    int cls;
    cls = int'($urandom_range(0, 2));
    bus.alloc_valid_i        = 1'b1;
    bus.alloc_pc_i           = pc;
    bus.alloc_pred_taken_i   = pt;
    bus.alloc_pred_target_i  = tgt;
    bus.alloc_target_valid_i = tv;
    bus.alloc_history_i      = h;
    bus.alloc_ras_tos_i      = RAS_W'($urandom);
    bus.alloc_is_branch_i    = (cls == 0);
    bus.alloc_is_call_i      = (cls == 1);
    bus.alloc_is_return_i    = (cls == 2);
  endtask

  task automatic drive_resolve(input logic [TAG_W-1:0] tag, input logic tk, input logic [31:0] tgt);
    bus.resolve_valid_i  = 1'b1;
    bus.resolve_tag_i    = tag;
    bus.resolve_taken_i  = tk;
    bus.resolve_target_i = tgt;
  endtask

  // Apply one clock edge's worth of queue semantics to the model.
  task automatic model_edge();
    int   k;
    logic mis, ret, rdy;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      m_tail = 0;
      e_mp   = 1'b0;
      e_uv   = 1'b0;
      if (rst) begin
        e_redir = '0;
        e_rhist = '0;
        e_rras  = '0;
      end
      return;
    end
    rdy = (mq.size() < DEPTH) && !e_mp;
    k   = -1;
    if (bus.resolve_valid_i)
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].tag == bus.resolve_tag_i && !mq[j].res) k = j;
    mis = 1'b0;
    if (k >= 0)
      mis = (bus.resolve_taken_i != mq[k].pt) ||
            (bus.resolve_taken_i && (!mq[k].tv || bus.resolve_target_i != mq[k].ptgt));
    ret  = !e_mp && !mis && (mq.size() > 0) && mq[0].res;
    e_uv = ret;
    e_mp = mis;
    if (ret) e_upd = mq[0];
    if (k >= 0) begin
      mq[k].res  = 1'b1;
      mq[k].at   = bus.resolve_taken_i;
      mq[k].atgt = bus.resolve_target_i;
    end
    if (mis) begin
      e_redir = bus.resolve_taken_i ? bus.resolve_target_i : mq[k].pc + 32'd4;
      e_rhist = mq[k].hist;
      e_rras  = mq[k].ras;
      while (mq.size() > k + 1) void'(mq.pop_back());
      m_tail = (int'(mq[k].tag) + 1) % DEPTH;
    end
    if (ret) void'(mq.pop_front());
    if (bus.alloc_valid_i && rdy && !mis) begin
      e.tag  = TAG_W'(m_tail);
      e.pc   = bus.alloc_pc_i;
      e.pt   = bus.alloc_pred_taken_i;
      e.ptgt = bus.alloc_pred_target_i;
      e.tv   = bus.alloc_target_valid_i;
      e.hist = bus.alloc_history_i;
      e.ras  = bus.alloc_ras_tos_i;
      e.br   = bus.alloc_is_branch_i;
      e.ca   = bus.alloc_is_call_i;
      e.re   = bus.alloc_is_return_i;
      e.res  = 1'b0;
      e.at   = 1'b0;
      e.atgt = '0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic check_outputs();
    chk("alloc_ready",  64'(bus.alloc_ready_o),  64'((mq.size() < DEPTH) && !e_mp));
    chk("alloc_tag",    64'(bus.alloc_tag_o),    64'(m_tail));
    chk("count",        64'(bus.count_o),        64'(mq.size()));
    chk("update_valid", 64'(bus.update_valid_o), 64'(e_uv));
    chk("mispredict",   64'(bus.mispredict_o),   64'(e_mp));
    if (e_uv) begin
      chk("upd_pc",     64'(bus.update_pc_o),        64'(e_upd.pc));
      chk("upd_taken",  64'(bus.update_taken_o),     64'(e_upd.at));
      chk("upd_target", 64'(bus.update_target_o),    64'(e_upd.atgt));
      chk("upd_class",  64'({bus.update_is_branch_o, bus.update_is_call_o, bus.update_is_return_o}),
                        64'({e_upd.br, e_upd.ca, e_upd.re}));
      chk("upd_hist",   64'(bus.update_history_o),   64'(e_upd.hist));
    end
    if (e_mp) begin
      chk("redirect",   64'(bus.redirect_pc_o),     64'(e_redir));
      chk("rec_hist",   64'(bus.recover_history_o), 64'(e_rhist));
      chk("rec_ras",    64'(bus.recover_ras_tos_o), 64'(e_rras));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_alloc();
    drive_alloc($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(0, 9) < 8), HIST_W'($urandom));
  endtask

  logic [31:0]       pcs   [3];
  logic [HIST_W-1:0] hists [5];
  logic [TAG_W-1:0]  rtag;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    chk("rst_redirect", 64'(bus.redirect_pc_o),     64'(0));
    chk("rst_upd_pc",   64'(bus.update_pc_o),       64'(0));
    chk("rst_rec_hist", 64'(bus.recover_history_o), 64'(0));
    cycle();

    // Fill to capacity; the ninth request must bounce.
    for (int i = 0; i < 9; i++) begin
      idle(); rand_alloc(); cycle();
    end
    idle();
    chk("full_count", 64'(bus.count_o),       64'(8));
    chk("full_ready", 64'(bus.alloc_ready_o), 64'(0));
    chk("full_tag",   64'(bus.alloc_tag_o),   64'(0));
    cycle();
    flush = 1'b1; cycle(); idle();

    // Out-of-order resolve, in-order retire.
    for (int i = 0; i < 3; i++) begin
      idle();
      pcs[i] = $urandom & 32'hFFFF_FFFC;
      drive_alloc(pcs[i], 1'b0, $urandom, 1'b1, HIST_W'($urandom));
      cycle();
    end
    idle(); cycle();
    idle(); drive_resolve(3'd2, 1'b0, $urandom); cycle();
    idle(); drive_resolve(3'd1, 1'b0, $urandom); cycle();
    idle(); drive_resolve(3'd0, 1'b0, $urandom); cycle();
    idle(); cycle();
    for (int i = 0; i < 3; i++) begin
      chk("ooo_upd_valid", 64'(bus.update_valid_o), 64'(1));
      chk("ooo_upd_pc",    64'(bus.update_pc_o),    64'(pcs[i]));
      cycle();
    end
    chk("ooo_count", 64'(bus.count_o), 64'(0));

    // Direction mispredict on tag 1 of five.
    flush = 1'b1; cycle(); idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      hists[i] = HIST_W'($urandom);
      drive_alloc($urandom & 32'hFFFF_FFFC, 1'b0, $urandom, 1'b1, hists[i]);
      cycle();
    end
    idle(); drive_resolve(3'd1, 1'b1, 32'h1000); cycle();
    idle(); drive_resolve(3'd3, 1'($urandom), $urandom);
    chk("dir_mp",       64'(bus.mispredict_o),      64'(1));
    chk("dir_redirect", 64'(bus.redirect_pc_o),     64'(32'h1000));
    chk("dir_rec_hist", 64'(bus.recover_history_o), 64'(hists[1]));
    chk("dir_count",    64'(bus.count_o),           64'(2));
    cycle();
    idle();
    chk("dir_count_after", 64'(bus.count_o), 64'(2));
    drive_resolve(3'd0, 1'b0, 32'h0); cycle();
    idle(); repeat (4) cycle();
    chk("dir_drained", 64'(bus.count_o), 64'(0));

    // Target mispredict: right direction, wrong target.
    flush = 1'b1; cycle(); idle();
    drive_alloc(32'h0000_0100, 1'b1, 32'h200, 1'b1, HIST_W'($urandom)); cycle();
    idle(); drive_resolve(3'd0, 1'b1, 32'h300); cycle();
    idle();
    chk("tgt_mp",       64'(bus.mispredict_o),  64'(1));
    chk("tgt_redirect", 64'(bus.redirect_pc_o), 64'(32'h300));
    repeat (3) cycle();

    // Pointer wrap: tags cycle through every index more than twice.
    for (int r = 0; r < 20; r++) begin
      idle(); drive_alloc($urandom & 32'hFFFF_FFFC, 1'b0, $urandom, 1'b1, HIST_W'($urandom));
      rtag = TAG_W'(m_tail);
      cycle();
      idle(); drive_resolve(rtag, 1'b0, $urandom); cycle();
      idle(); cycle(); cycle();
    end
    chk("wrap_count", 64'(bus.count_o), 64'(0));

    // Flush beats a same-cycle mispredict and alloc.
    flush = 1'b1; cycle(); idle();
    for (int i = 0; i < 5; i++) begin
      idle(); drive_alloc($urandom & 32'hFFFF_FFFC, 1'b0, $urandom, 1'b1, HIST_W'($urandom)); cycle();
    end
    idle();
    drive_alloc(32'h40, 1'b0, 32'h0, 1'b1, '0);
    drive_resolve(3'd2, 1'b1, 32'h800);
    flush = 1'b1;
    cycle();
    idle();
    chk("flush_count", 64'(bus.count_o),      64'(0));
    chk("flush_mp",    64'(bus.mispredict_o), 64'(0));
    chk("flush_tag",   64'(bus.alloc_tag_o),  64'(0));
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 99) < 60) rand_alloc();
      if ($urandom_range(0, 99) < 50) begin
        if (mq.size() > 0) begin
          int j;
          j = int'($urandom_range(0, mq.size() - 1));
          drive_resolve(mq[j].tag,
                        ($urandom_range(0, 99) < 75) ? mq[j].pt : !mq[j].pt,
                        ($urandom_range(0, 99) < 75) ? mq[j].ptgt : $urandom);
          if ($urandom_range(0, 3) == 0) bus.resolve_tag_i = TAG_W'($urandom);
        end else begin
          drive_resolve(TAG_W'($urandom), 1'($urandom), $urandom);
        end
      end
      if ($urandom_range(0, 99) < 2) flush = 1'b1;
      cycle();
    end
    idle();
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
